// File: rtl/conv3x3_sequencer.sv
// 3x3 convolution tap sequencer: walks the coefficient ROM and frame buffer
// for one output pixel, multiply-accumulates the taps with zero padding at the
// image border and hands the result downstream on a valid/ready handshake.
//
//  state   | meaning
//  IDLE    | waiting for start; range-checks the requested centre
//  FETCH   | issuing taps 0..8, one per cycle
//  DRAIN   | accumulating the last tap's returned data
//  DONE    | result_valid high until result_ready
module conv3x3_sequencer #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 9,
    parameter int ACC_W  = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cx,
    input  logic [ADDR_W-1:0] cy,
    output logic              busy,
    output logic              cfg_err,
    output logic              filt_en,
    output logic [3:0]        filt_addr,
    input  logic [COEF_W-1:0] filt_coef,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result_acc,
    output logic [PIX_W-1:0]  result_pix
);
    localparam int PROD_W = COEF_W + PIX_W + 1;
    localparam logic [ADDR_W-1:0] W_L    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] H_L    = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] XMAX_L = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] YMAX_L = ADDR_W'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          k_q;
    logic [ADDR_W-1:0]   cx_q, cy_q;
    logic                issued_q, pad_q, cfg_err_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                start_ok, start_bad;
    logic [1:0]          row_sel, col_sel;
    logic                in_img;
    logic [ADDR_W-1:0]   row, col, lin;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign start_ok  = start && (cx < W_L) && (cy < H_L);
    assign start_bad = start && !((cx < W_L) && (cy < H_L));

    // Tap k -> (row,col) offset codes 0..2 (offset+1), border test and linear address
    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (k_q)
            4'd0: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7: begin row_sel = 2'd2; col_sel = 2'd1; end
            4'd8: begin row_sel = 2'd2; col_sel = 2'd2; end
            default: begin row_sel = 2'd1; col_sel = 2'd1; end
        endcase
        in_img = !((row_sel == 2'd0) && (cy_q == '0)) &&
                 !((row_sel == 2'd2) && (cy_q == YMAX_L)) &&
                 !((col_sel == 2'd0) && (cx_q == '0)) &&
                 !((col_sel == 2'd2) && (cx_q == XMAX_L));
        row = cy_q + ADDR_W'(row_sel) - ADDR_W'(1);
        col = cx_q + ADDR_W'(col_sel) - ADDR_W'(1);
        lin = row * W_L + col;
    end

    // Signed coefficient times unsigned pixel, sign-extended into the accumulator
    always_comb begin
        prod     = $signed(filt_coef) * $signed({1'b0, pix_data});
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_FETCH;
            S_FETCH: if (k_q == 4'd8) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (result_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; reads only in FETCH, padded taps suppress pix_rd
    always_comb begin
        busy         = (state_q != S_IDLE);
        filt_en      = 1'b0;
        filt_addr    = 4'd0;
        pix_rd       = 1'b0;
        pix_addr     = '0;
        result_valid = (state_q == S_DONE);
        if (state_q == S_FETCH) begin
            filt_en   = 1'b1;
            filt_addr = k_q;
            pix_rd    = in_img;
            pix_addr  = in_img ? lin : '0;
        end
    end

    // Tap counter, latched centre, one-cycle issue/pad pipeline and accumulator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q       <= 4'd0;
            cx_q      <= '0;
            cy_q      <= '0;
            issued_q  <= 1'b0;
            pad_q     <= 1'b0;
            acc_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && start_bad;
            issued_q  <= (state_q == S_FETCH);
            pad_q     <= (state_q == S_FETCH) && !in_img;
            if (state_q == S_IDLE && start_ok) begin
                cx_q  <= cx;
                cy_q  <= cy;
                k_q   <= 4'd0;
                acc_q <= '0;
            end else begin
                if (state_q == S_FETCH)
                    k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
                if (issued_q && !pad_q)
                    acc_q <= acc_q + prod_ext;
            end
        end
    end

    // Result is the raw accumulator plus an unsigned clamp to the pixel range
    always_comb begin
        cfg_err    = cfg_err_q;
        result_acc = acc_q;
        if (acc_q[ACC_W-1])        result_pix = '0;
        else if (acc_q > PIX_MAX)  result_pix = '1;
        else                       result_pix = acc_q[PIX_W-1:0];
    end
endmodule

// File: tb/tb_conv3x3_sequencer.sv
module tb_conv3x3_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cx = '0, cy = '0;
    logic        busy, cfg_err, filt_en, pix_rd, result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  filt_addr;
    logic [8:0]  filt_coef = '0;
    logic [15:0] pix_addr;
    logic [7:0]  pix_data = '0;
    logic [21:0] result_acc;
    logic [7:0]  result_pix;

    int n_chk = 0, n_pass = 0;

    logic [7:0]        img [256];
    logic signed [8:0] rom [9];

    int en_cnt, rd_cnt, seq_err, addr_err, stray, exp_k, cx_l, cy_l;
    logic [8:0] rd_mask;

    conv3x3_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cx(cx), .cy(cy),
        .busy(busy), .cfg_err(cfg_err), .filt_en(filt_en), .filt_addr(filt_addr),
        .filt_coef(filt_coef), .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_acc(result_acc), .result_pix(result_pix)
    );

    always #5 clk = ~clk;

    // ROM and frame buffer with 1-cycle read latency
    always @(posedge clk) begin
        if (filt_en && filt_addr < 4'd9) filt_coef <= rom[filt_addr];
        if (pix_rd) pix_data <= img[pix_addr[7:0]];
    end

    // Tap monitor: sequence, read mask, expected pixel addresses, stray strobes
    always @(posedge clk) begin
        if (filt_en) begin
            if (int'(filt_addr) != exp_k || filt_addr > 4'd8) seq_err++;
            if (filt_addr <= 4'd8) rd_mask[filt_addr] = pix_rd;
            exp_k++;
            en_cnt++;
            if (pix_rd) begin
                rd_cnt++;
                if (int'(pix_addr) != (cy_l + int'(filt_addr) / 3 - 1) * 16 + (cx_l + int'(filt_addr) % 3 - 1))
                    addr_err++;
            end
        end else if (pix_rd) begin
            stray++;
        end
    end

    task automatic clear_mon();
        en_cnt = 0; rd_cnt = 0; seq_err = 0; addr_err = 0; stray = 0; exp_k = 0; rd_mask = '0;
    endtask

    task automatic fill_flat(input logic [7:0] v);
        for (int i = 0; i < 256; i++) img[i] = v;
    endtask

    task automatic issue_start(input int x, input int y);
        clear_mon();
        cx_l = x; cy_l = y;
        @(posedge clk); #1;
        start = 1'b1; cx = 16'(x); cy = 16'(y);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges counted after the start edge until result_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_handshake();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({busy, cfg_err, filt_en, filt_addr, pix_rd, pix_addr, result_valid, result_acc, result_pix} !== '0)
            $display("FAIL reset_outputs got busy=%b en=%b rd=%b valid=%b acc=%0d want all 0",
                     busy, filt_en, pix_rd, result_valid, result_acc);
        else n_pass++;
        #10 reset = 1'b1;
    endtask

    task automatic test_flat();
        int lat;
        fill_flat(8'd100);
        issue_start(5, 5);
        wait_valid(lat);
        n_chk++;
        if (lat !== 10) $display("FAIL flat_latency got %0d edges want 10", lat); else n_pass++;
        n_chk++;
        if (en_cnt !== 9 || rd_cnt !== 9 || seq_err !== 0 || addr_err !== 0 || stray !== 0)
            $display("FAIL flat_taps got en=%0d rd=%0d seq_err=%0d addr_err=%0d stray=%0d want 9 9 0 0 0",
                     en_cnt, rd_cnt, seq_err, addr_err, stray);
        else n_pass++;
        n_chk++;
        if ($signed(result_acc) !== 22'sd0 || result_pix !== 8'd0)
            $display("FAIL flat_result got acc=%0d pix=%0d want 0 0", $signed(result_acc), result_pix);
        else n_pass++;
        finish_handshake();
    endtask

    task automatic test_single();
        int lat;
        fill_flat(8'd0);
        img[5*16+5] = 8'd200;
        issue_start(5, 5);
        wait_valid(lat);
        n_chk++;
        if (lat !== 10 || $signed(result_acc) !== 22'sd800 || result_pix !== 8'd255)
            $display("FAIL single_sat got lat=%0d acc=%0d pix=%0d want 10 800 255",
                     lat, $signed(result_acc), result_pix);
        else n_pass++;
        finish_handshake();
        issue_start(6, 5);
        wait_valid(lat);
        n_chk++;
        if (lat !== 10 || $signed(result_acc) !== -22'sd200 || result_pix !== 8'd0)
            $display("FAIL clamp_low got lat=%0d acc=%0d pix=%0d want 10 -200 0",
                     lat, $signed(result_acc), result_pix);
        else n_pass++;
        finish_handshake();
    endtask

    task automatic test_corner();
        int lat;
        fill_flat(8'd100);
        issue_start(0, 0);
        wait_valid(lat);
        n_chk++;
        if (rd_mask !== 9'h1B0 || rd_cnt !== 5'd4 || addr_err !== 0 || en_cnt !== 9)
            $display("FAIL corner00_reads got mask=%h rd=%0d addr_err=%0d en=%0d want 1b0 4 0 9",
                     rd_mask, rd_cnt, addr_err, en_cnt);
        else n_pass++;
        n_chk++;
        if ($signed(result_acc) !== 22'sd200 || result_pix !== 8'd200)
            $display("FAIL corner00_result got acc=%0d pix=%0d want 200 200", $signed(result_acc), result_pix);
        else n_pass++;
        finish_handshake();
        issue_start(15, 15);
        wait_valid(lat);
        n_chk++;
        if (rd_mask !== 9'h01B || addr_err !== 0 || $signed(result_acc) !== 22'sd200)
            $display("FAIL corner1515 got mask=%h addr_err=%0d acc=%0d want 01b 0 200",
                     rd_mask, addr_err, $signed(result_acc));
        else n_pass++;
        finish_handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        fill_flat(8'd0);
        img[5*16+5] = 8'd200;
        issue_start(5, 5);
        wait_valid(lat);
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); cx = 16'd5; cy = 16'd5;
            @(posedge clk); #1;
            start = 1'b0;
            n_chk++;
            if (result_valid !== 1'b1 || $signed(result_acc) !== 22'sd800 || result_pix !== 8'd255)
                $display("FAIL hold_%0d got valid=%b acc=%0d pix=%0d want 1 800 255",
                         i, result_valid, $signed(result_acc), result_pix);
            else n_pass++;
        end
        result_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || $signed(result_acc) !== 22'sd800 || result_pix !== 8'd255)
            $display("FAIL handshake_idle got busy=%b valid=%b acc=%0d pix=%0d want 0 0 800 255",
                     busy, result_valid, $signed(result_acc), result_pix);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || en_cnt !== 0 || stray !== 0)
            $display("FAIL start_not_queued got busy=%b en=%0d stray=%0d want 0 0 0", busy, en_cnt, stray);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, guard;
        fill_flat(8'd100);
        issue_start(5, 5);
        guard = 0;
        while (!(filt_en && filt_addr == 4'd4) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_chk++;
        if (guard >= 20) $display("FAIL tap4_timeout got no tap 4 within 20 cycles want tap 4");
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({busy, cfg_err, filt_en, filt_addr, pix_rd, pix_addr, result_valid, result_acc, result_pix} !== '0)
            $display("FAIL reset_mid got busy=%b en=%b addr=%0d rd=%b paddr=%0d valid=%b acc=%0d want all 0",
                     busy, filt_en, filt_addr, pix_rd, pix_addr, result_valid, result_acc);
        else n_pass++;
        #3 reset = 1'b1;
        issue_start(16, 3);
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL cfg_err_pulse got cfg_err=%b busy=%b want 1 0", cfg_err, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || en_cnt !== 0 || stray !== 0)
            $display("FAIL cfg_err_end got cfg_err=%b busy=%b en=%0d stray=%0d want 0 0 0 0",
                     cfg_err, busy, en_cnt, stray);
        else n_pass++;
        issue_start(5, 5);
        wait_valid(lat);
        n_chk++;
        if (lat !== 10 || en_cnt !== 9 || rd_cnt !== 9 || $signed(result_acc) !== 22'sd0 || result_pix !== 8'd0)
            $display("FAIL after_reset got lat=%0d en=%0d rd=%0d acc=%0d pix=%0d want 10 9 9 0 0",
                     lat, en_cnt, rd_cnt, $signed(result_acc), result_pix);
        else n_pass++;
        finish_handshake();
    endtask

    initial begin
        rom[0] = 9'sd0;  rom[1] = -9'sd1; rom[2] = 9'sd0;
        rom[3] = -9'sd1; rom[4] = 9'sd4;  rom[5] = -9'sd1;
        rom[6] = 9'sd0;  rom[7] = -9'sd1; rom[8] = 9'sd0;
        clear_mon();
        cx_l = 0; cy_l = 0;
        test_reset();
        test_flat();
        test_single();
        test_corner();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
